// File: rtl/pipelined_pc_ifid_if.sv
// Fetch/decode bundle between the fetch stage, the hazard unit and the PC + IF/ID latch.
// The counter signals exist only when PIPE_PERF_CNT_EN is defined.
interface pipelined_pc_ifid_if;
   logic [31:0] Next_PC;
   logic [31:0] PC_plus4;
   logic [31:0] IF_Inst;
   logic        Stall;
   logic        Flush;
   logic [31:0] PC;
   logic [31:0] ID_PC4;
   logic [31:0] ID_Inst;
   logic        ID_Valid;
   logic        Align_Err;
`ifdef PIPE_PERF_CNT_EN
   logic [15:0] Stall_Cnt;
   logic [15:0] Flush_Cnt;
`endif

   modport master (
      output Next_PC, PC_plus4, IF_Inst, Stall, Flush,
`ifdef PIPE_PERF_CNT_EN
      input  Stall_Cnt, Flush_Cnt,
`endif
      input  PC, ID_PC4, ID_Inst, ID_Valid, Align_Err
   );

   modport slave (
      input  Next_PC, PC_plus4, IF_Inst, Stall, Flush,
`ifdef PIPE_PERF_CNT_EN
      output Stall_Cnt, Flush_Cnt,
`endif
      output PC, ID_PC4, ID_Inst, ID_Valid, Align_Err
   );
endinterface

// File: rtl/pipelined_pc_ifid.sv
// PC register and IF/ID latch with stall/flush priority and sticky misalignment flag.
// Optional stall/flush performance counters are enabled by defining PIPE_PERF_CNT_EN.
module pipelined_pc_ifid #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
   input logic                Clk,
   input logic                Clrn,
   pipelined_pc_ifid_if.slave bus
);

   logic [31:0] r_pc;
   logic [31:0] r_id_pc4;
   logic [31:0] r_id_inst;
   logic        r_id_valid;
   logic        r_align_err;

   logic        w_load;
   logic [31:0] w_pc_next;
   logic        w_misalign;

   assign w_load     = ~bus.Stall;
   assign w_pc_next  = {bus.Next_PC[31:2], 2'b00};
   assign w_misalign = |bus.Next_PC[1:0];

   // A stalled edge freezes everything, so a coincident flush is simply dropped.
   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_pc        <= RESET_PC;
         r_id_pc4    <= 32'h0;
         r_id_inst   <= NOP_INST;
         r_id_valid  <= 1'b0;
         r_align_err <= 1'b0;
      end else if (w_load) begin
         r_pc <= w_pc_next;
         if (w_misalign) r_align_err <= 1'b1;
         if (bus.Flush) begin
            r_id_pc4   <= 32'h0;
            r_id_inst  <= NOP_INST;
            r_id_valid <= 1'b0;
         end else begin
            r_id_pc4   <= bus.PC_plus4;
            r_id_inst  <= bus.IF_Inst;
            r_id_valid <= 1'b1;
         end
      end
   end

   assign bus.PC        = r_pc;
   assign bus.ID_PC4    = r_id_pc4;
   assign bus.ID_Inst   = r_id_inst;
   assign bus.ID_Valid  = r_id_valid;
   assign bus.Align_Err = r_align_err;

`ifdef PIPE_PERF_CNT_EN
   logic [15:0] r_stall_cnt;
   logic [15:0] r_flush_cnt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge Clk or negedge Clrn) begin
      if (!Clrn) begin
         r_stall_cnt <= 16'h0;
         r_flush_cnt <= 16'h0;
      end else begin
         if (bus.Stall) r_stall_cnt <= sat_inc(r_stall_cnt);
         if (w_load && bus.Flush) r_flush_cnt <= sat_inc(r_flush_cnt);
      end
   end

   assign bus.Stall_Cnt = r_stall_cnt;
   assign bus.Flush_Cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipelined_pc_ifid.sv
// Randomized bench for pipelined_pc_ifid with a behavioural reference model and directed pins.
module tb_pipelined_pc_ifid;
   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic Clk = 1'b0;
   logic Clrn = 1'b0;
   int   total = 0;
   int   bad = 0;

   pipelined_pc_ifid_if bus();

   pipelined_pc_ifid #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .Clk(Clk), .Clrn(Clrn), .bus(bus)
   );

   always #5 Clk = ~Clk;

   // Behavioural reference model.
   logic [31:0] m_pc, m_pc4, m_inst;
   logic        m_vld, m_err;
   int          m_sc, m_fc;

   task automatic model_reset();
      m_pc = RST_PC; m_pc4 = 0; m_inst = NOP; m_vld = 0; m_err = 0;
      m_sc = 0; m_fc = 0;
   endtask

   always @(posedge Clk or negedge Clrn) begin
      if (!Clrn) model_reset();
      else if (bus.Stall) begin
         if (m_sc < 65535) m_sc = m_sc + 1;
      end else begin
         m_pc = bus.Next_PC - (bus.Next_PC % 4);
         if (bus.Next_PC % 4 != 0) m_err = 1;
         if (bus.Flush) begin
            m_inst = NOP; m_pc4 = 0; m_vld = 0;
            if (m_fc < 65535) m_fc = m_fc + 1;
         end else begin
            m_inst = bus.IF_Inst; m_pc4 = bus.PC_plus4; m_vld = 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      check("cmp_pc", bus.PC, m_pc);
      check("cmp_pc4", bus.ID_PC4, m_pc4);
      check("cmp_inst", bus.ID_Inst, m_inst);
      check("cmp_valid", {31'h0, bus.ID_Valid}, {31'h0, m_vld});
      check("cmp_err", {31'h0, bus.Align_Err}, {31'h0, m_err});
`ifdef PIPE_PERF_CNT_EN
      check("cmp_scnt", {16'h0, bus.Stall_Cnt}, m_sc);
      check("cmp_fcnt", {16'h0, bus.Flush_Cnt}, m_fc);
`endif
   end

   task automatic drive(input logic [31:0] np, input logic [31:0] p4, input logic [31:0] inst,
                        input logic st, input logic fl);
      bus.Next_PC = np; bus.PC_plus4 = p4; bus.IF_Inst = inst;
      bus.Stall = st; bus.Flush = fl;
      @(posedge Clk);
      #1;
   endtask

   task automatic drive_rand();
      drive($urandom, $urandom, $urandom, 1'($urandom), 1'($urandom));
   endtask

   logic [31:0] s_inst, s_pc4, s_pc;
   logic        s_vld;
   logic [15:0] s_fc;

   initial begin
      model_reset();
      bus.Next_PC = 0; bus.PC_plus4 = 0; bus.IF_Inst = 0; bus.Stall = 0; bus.Flush = 0;
      s_fc = 0;

      // Reset held with random inputs.
      repeat (3) drive_rand();
      check("rst_pc", bus.PC, RST_PC);
      check("rst_inst", bus.ID_Inst, NOP);
      check("rst_pc4", bus.ID_PC4, 32'h0);
      check("rst_valid", {31'h0, bus.ID_Valid}, 32'h0);
      check("rst_err", {31'h0, bus.Align_Err}, 32'h0);
      Clrn = 1'b1;

      drive(32'h4, 32'h4, 32'h2008_0005, 0, 0);
      check("first_pc", bus.PC, 32'h4);
      check("first_inst", bus.ID_Inst, 32'h2008_0005);
      check("first_pc4", bus.ID_PC4, 32'h4);
      check("first_valid", {31'h0, bus.ID_Valid}, 32'h1);

      // Stall holds PC and the latch.
      drive(32'h10, 32'h8, 32'hAAAA_0001, 0, 0);
      check("pre_stall_pc", bus.PC, 32'h10);
      for (int i = 0; i < 3; i++) begin
         drive(32'h14, 32'h14, 32'hBBBB_0002, 1, 0);
         check("stall_pc", bus.PC, 32'h10);
         check("stall_inst", bus.ID_Inst, 32'hAAAA_0001);
         check("stall_pc4", bus.ID_PC4, 32'h8);
      end
      drive(32'h14, 32'h14, 32'hBBBB_0002, 0, 0);
      check("unstall_pc", bus.PC, 32'h14);
      check("unstall_inst", bus.ID_Inst, 32'hBBBB_0002);

      // Flush injects a bubble.
      drive(32'h40, 32'h18, 32'h8C09_0000, 0, 1);
      check("flush_pc", bus.PC, 32'h40);
      check("flush_inst", bus.ID_Inst, NOP);
      check("flush_pc4", bus.ID_PC4, 32'h0);
      check("flush_valid", {31'h0, bus.ID_Valid}, 32'h0);

      // Stall + flush: nothing changes.
      drive(32'h44, 32'h44, 32'h1234_5678, 0, 0);
      s_pc = bus.PC; s_inst = bus.ID_Inst; s_pc4 = bus.ID_PC4; s_vld = bus.ID_Valid;
`ifdef PIPE_PERF_CNT_EN
      s_fc = bus.Flush_Cnt;
`endif
      drive(32'h80, 32'h84, 32'hDEAD_BEEF, 1, 1);
      check("sf_pc", bus.PC, s_pc);
      check("sf_inst", bus.ID_Inst, s_inst);
      check("sf_pc4", bus.ID_PC4, s_pc4);
      check("sf_valid", {31'h0, bus.ID_Valid}, {31'h0, s_vld});
`ifdef PIPE_PERF_CNT_EN
      check("sf_fcnt", {16'h0, bus.Flush_Cnt}, {16'h0, s_fc});
`endif

      // Misaligned accepted Next_PC sets a sticky flag.
      drive(32'h22, 32'h26, 32'h0000_0001, 0, 0);
      check("mis_pc", bus.PC, 32'h20);
      check("mis_err", {31'h0, bus.Align_Err}, 32'h1);
      for (int i = 0; i < 5; i++) drive(32'h30 + 32'(4 * i), 32'h0, 32'h0, 0, 0);
      check("mis_sticky", {31'h0, bus.Align_Err}, 32'h1);

      // Misaligned under stall is ignored.
      Clrn = 1'b0; #2; Clrn = 1'b1;
      drive(32'h23, 32'h27, 32'h0000_0002, 1, 0);
      check("mis_stall_err", {31'h0, bus.Align_Err}, 32'h0);
      check("mis_stall_pc", bus.PC, RST_PC);

      // Random traffic, mostly aligned, with occasional asynchronous resets.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] np;
         np = $urandom;
         if ($urandom_range(0, 9) != 0) np[1:0] = 2'b00;
         if ($urandom_range(0, 39) == 0) begin
            Clrn = 1'b0; #2;
            check("async_rst_pc", bus.PC, RST_PC);
            check("async_rst_valid", {31'h0, bus.ID_Valid}, 32'h0);
            Clrn = 1'b1;
         end
         drive(np, $urandom, $urandom, ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      end

`ifdef PIPE_PERF_CNT_EN
      Clrn = 1'b0; #2; Clrn = 1'b1;
      for (int i = 0; i < 65540; i++) drive($urandom, $urandom, $urandom, 1, 1'($urandom));
      check("scnt_sat", {16'h0, bus.Stall_Cnt}, 32'h0000_FFFF);
      #2; Clrn = 1'b0; #1;
      check("scnt_rst", {16'h0, bus.Stall_Cnt}, 32'h0);
      check("scnt_rst_pc", bus.PC, RST_PC);
      #2; Clrn = 1'b1;
      drive(32'h8, 32'h8, 32'h1, 0, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
